// File: rtl/cmd_stream_router_pkg.sv
// Shared constants and state encoding for the command stream router.
package cmd_stream_router_pkg;

   localparam int unsigned MAX_DIM_DEF     = 16;
   localparam int unsigned SRAM_AW_DEF     = 10;

   localparam logic [7:0] OP_LOAD_VEC      = 8'h01;
   localparam logic [7:0] OP_MATMUL        = 8'h02;

   localparam logic [1:0] ERR_NONE         = 2'd0;
   localparam logic [1:0] ERR_OPCODE       = 2'd1;
   localparam logic [1:0] ERR_LEN          = 2'd2;
   localparam logic [1:0] ERR_DIMS         = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LV_LEN    = 3'd1,
      ST_LV_DATA   = 3'd2,
      ST_MM_VDIM   = 3'd3,
      ST_MM_HDIM   = 3'd4,
      ST_MM_EMIT_V = 3'd5,
      ST_MM_EMIT_H = 3'd6,
      ST_MM_BODY   = 3'd7
   } state_t;

endpackage

// File: rtl/cmd_stream_router.sv
// Parses the host byte stream: vector loads go to the SRAM write port,
// validated matmul headers plus matrix body go to the multiplier.
module cmd_stream_router
   import cmd_stream_router_pkg::*;
#(
   parameter int unsigned MAX_DIM         = MAX_DIM_DEF,
   parameter int unsigned SRAM_ADDR_WIDTH = SRAM_AW_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [7:0]                 in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [7:0]                 mm_data,
   output logic                       mm_valid,
   input  logic                       mm_ready,
   output logic                       sram_we,
   output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
   output logic [7:0]                 sram_din,
   output logic [7:0]                 vec_len,
   output logic                       busy,
   output logic                       err,
   output logic [1:0]                 err_code
);

   state_t                     state_q, state_d;
   logic [7:0]                 len_q, len_d;
   logic [7:0]                 cnt_q, cnt_d;
   logic [7:0]                 vdim_q, vdim_d;
   logic [7:0]                 hdim_q, hdim_d;
   logic [7:0]                 vec_len_q, vec_len_d;
   logic [15:0]                rem_q, rem_d;
   logic                       we_q, we_d;
   logic [SRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                 din_q, din_d;
   logic                       err_q, err_d;
   logic [1:0]                 code_q, code_d;

   logic in_fire;
   logic mm_fire;
   logic len_ok;
   logic dims_ok;
   logic lv_last;

   assign in_fire = in_valid && in_ready;
   assign mm_fire = mm_valid && mm_ready;
   assign len_ok  = (in_data != 8'd0) && (in_data <= 8'(MAX_DIM));
   // hdim arrives on in_data in MM_HDIM; vdim was latched the cycle before
   assign dims_ok = (vdim_q != 8'd0) && (in_data != 8'd0) &&
                    (in_data <= 8'(MAX_DIM)) && (in_data <= vec_len_q);
   assign lv_last = (cnt_q == len_q - 8'd1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (in_fire) begin
               if (in_data == OP_LOAD_VEC)     state_d = ST_LV_LEN;
               else if (in_data == OP_MATMUL)  state_d = ST_MM_VDIM;
            end
         end
         ST_LV_LEN:    if (in_fire) state_d = len_ok ? ST_LV_DATA : ST_IDLE;
         ST_LV_DATA:   if (in_fire && lv_last) state_d = ST_IDLE;
         ST_MM_VDIM:   if (in_fire) state_d = ST_MM_HDIM;
         ST_MM_HDIM:   if (in_fire) state_d = dims_ok ? ST_MM_EMIT_V : ST_IDLE;
         ST_MM_EMIT_V: if (mm_ready) state_d = ST_MM_EMIT_H;
         ST_MM_EMIT_H: if (mm_ready) state_d = ST_MM_BODY;
         ST_MM_BODY:   if (mm_fire && (rem_q == 16'd1)) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs and datapath next values
   always_comb begin
      in_ready  = 1'b0;
      mm_valid  = 1'b0;
      mm_data   = 8'd0;
      len_d     = len_q;
      cnt_d     = cnt_q;
      vdim_d    = vdim_q;
      hdim_d    = hdim_q;
      vec_len_d = vec_len_q;
      rem_d     = rem_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      din_d     = din_q;
      err_d     = 1'b0;
      code_d    = code_q;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_fire && (in_data != OP_LOAD_VEC) && (in_data != OP_MATMUL)) begin
               err_d  = 1'b1;
               code_d = ERR_OPCODE;
            end
         end
         ST_LV_LEN: begin
            in_ready = 1'b1;
            if (in_fire) begin
               if (len_ok) begin
                  len_d = in_data;
                  cnt_d = 8'd0;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_LEN;
               end
            end
         end
         ST_LV_DATA: begin
            in_ready = 1'b1;
            if (in_fire) begin
               we_d   = 1'b1;
               addr_d = SRAM_ADDR_WIDTH'(cnt_q);
               din_d  = in_data;
               cnt_d  = cnt_q + 8'd1;
               if (lv_last) vec_len_d = len_q;
            end
         end
         ST_MM_VDIM: begin
            in_ready = 1'b1;
            if (in_fire) vdim_d = in_data;
         end
         ST_MM_HDIM: begin
            in_ready = 1'b1;
            if (in_fire) begin
               hdim_d = in_data;
               if (dims_ok) begin
                  rem_d = 16'(vdim_q) * 16'(in_data);
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_DIMS;
               end
            end
         end
         ST_MM_EMIT_V: begin
            mm_valid = 1'b1;
            mm_data  = vdim_q;
         end
         ST_MM_EMIT_H: begin
            mm_valid = 1'b1;
            mm_data  = hdim_q;
         end
         ST_MM_BODY: begin
            // zero-latency pass-through, backpressure straight to the host
            in_ready = mm_ready;
            mm_valid = in_valid;
            mm_data  = in_data;
            if (mm_fire) rem_d = rem_q - 16'd1;
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         len_q     <= 8'd0;
         cnt_q     <= 8'd0;
         vdim_q    <= 8'd0;
         hdim_q    <= 8'd0;
         vec_len_q <= 8'd0;
         rem_q     <= 16'd0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         din_q     <= 8'd0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         vdim_q    <= vdim_d;
         hdim_q    <= hdim_d;
         vec_len_q <= vec_len_d;
         rem_q     <= rem_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         din_q     <= din_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   assign sram_we   = we_q;
   assign sram_addr = addr_q;
   assign sram_din  = din_q;
   assign vec_len   = vec_len_q;
   assign busy      = (state_q != ST_IDLE);
   assign err       = err_q;
   assign err_code  = code_q;

endmodule

// File: tb/tb_cmd_stream_router.sv
// Directed bench for cmd_stream_router: loads, matmul forwarding, error paths,
// mid-command reset and a full-size back-to-back transfer.
module tb_cmd_stream_router;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] mm_data;
   logic       mm_valid;
   logic       mm_ready;
   logic       sram_we;
   logic [9:0] sram_addr;
   logic [7:0] sram_din;
   logic [7:0] vec_len;
   logic       busy;
   logic       err;
   logic [1:0] err_code;

   typedef struct {
      int         c;
      logic [9:0] a;
      logic [7:0] d;
   } wr_t;

   wr_t        wr_q[$];
   logic [7:0] mm_q[$];
   logic [7:0] exp3[8];
   int         cyc = 0;
   int         mmv_cnt = 0;
   int         err_cnt = 0;
   int         n_assert = 0;
   int         n_fail = 0;
   int         last_acc = 0;
   logic       tog_en = 1'b0;

   cmd_stream_router dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mm_data   (mm_data),
      .mm_valid  (mm_valid),
      .mm_ready  (mm_ready),
      .sram_we   (sram_we),
      .sram_addr (sram_addr),
      .sram_din  (sram_din),
      .vec_len   (vec_len),
      .busy      (busy),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // multiplier backpressure: constant ready or toggling every cycle
   always @(negedge clk) mm_ready = tog_en ? ~mm_ready : 1'b1;

   // observe transfers just before each rising edge
   always @(negedge clk) begin
      #4;
      if (sram_we) wr_q.push_back('{cyc, sram_addr, sram_din});
      if (mm_valid && mm_ready) mm_q.push_back(mm_data);
      if (mm_valid) mmv_cnt++;
      if (err) err_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   // present one byte and hold it until accepted (bounded)
   task automatic send(input logic [7:0] b);
      int w;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      #1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!in_ready) begin
         chk("send_timeout", 32'(in_ready), 32'd1);
      end else begin
         @(posedge clk);
         #1;
         last_acc = cyc;
      end
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'd0;
      #1;
   endtask

   initial begin
      int bad;
      int h;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'd0;
      exp3     = '{8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

      // reset values
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_mm_valid",  32'(mm_valid),  32'd0);
      chk("rst_mm_data",   32'(mm_data),   32'd0);
      chk("rst_sram_we",   32'(sram_we),   32'd0);
      chk("rst_sram_addr", 32'(sram_addr), 32'd0);
      chk("rst_sram_din",  32'(sram_din),  32'd0);
      chk("rst_vec_len",   32'(vec_len),   32'd0);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_err",       32'(err),       32'd0);
      chk("rst_err_code",  32'(err_code),  32'd0);

      // LOAD_VEC len 3
      wr_q.delete();
      send(8'h01); send(8'h03); send(8'h0A); send(8'h0B); send(8'h0C);
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("lv_wr_count", 32'(wr_q.size()), 32'd3);
      if (wr_q.size() == 3) begin
         chk("lv_wr0_addr", 32'(wr_q[0].a), 32'd0);
         chk("lv_wr0_data", 32'(wr_q[0].d), 32'h0A);
         chk("lv_wr1_addr", 32'(wr_q[1].a), 32'd1);
         chk("lv_wr1_data", 32'(wr_q[1].d), 32'h0B);
         chk("lv_wr2_addr", 32'(wr_q[2].a), 32'd2);
         chk("lv_wr2_data", 32'(wr_q[2].d), 32'h0C);
         chk("lv_wr_consecutive", 32'(wr_q[2].c - wr_q[0].c), 32'd2);
      end
      chk("lv_vec_len", 32'(vec_len), 32'd3);
      chk("lv_busy",    32'(busy),    32'd0);

      // MATMUL 2x3 with toggling multiplier ready
      mm_q.delete();
      tog_en = 1'b1;
      send(8'h02); send(8'h02); send(8'h03);
      for (int i = 0; i < 6; i++) send(8'(8'h10 + i));
      idle();
      chk("mm_busy_after", 32'(busy), 32'd0);
      tog_en = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("mm_count", 32'(mm_q.size()), 32'd8);
      bad = 0;
      for (int i = 0; i < 8; i++)
         if (i >= mm_q.size() || mm_q[i] !== exp3[i]) bad++;
      chk("mm_stream_order", 32'(bad), 32'd0);
      chk("mm_no_err", 32'(err_cnt), 32'd0);

      // MATMUL with hdim larger than loaded vector
      mmv_cnt = 0;
      send(8'h02); send(8'h02); send(8'h04);
      idle();
      chk("dims_err_pulse", 32'(err),      32'd1);
      chk("dims_err_code",  32'(err_code), 32'd3);
      @(negedge clk);
      #1;
      chk("dims_err_one_cycle", 32'(err),      32'd0);
      chk("dims_code_held",     32'(err_code), 32'd3);
      chk("dims_busy",          32'(busy),     32'd0);
      chk("dims_no_mm_valid",   32'(mmv_cnt),  32'd0);

      // bad opcode
      send(8'h07);
      idle();
      chk("op_err_pulse", 32'(err),      32'd1);
      chk("op_err_code",  32'(err_code), 32'd1);
      chk("op_in_ready",  32'(in_ready), 32'd1);
      chk("op_busy",      32'(busy),     32'd0);

      // LOAD_VEC with len 0 and len 17
      send(8'h01); send(8'h00);
      idle();
      chk("len0_err_pulse", 32'(err),      32'd1);
      chk("len0_err_code",  32'(err_code), 32'd2);
      chk("len0_busy",      32'(busy),     32'd0);
      send(8'h01); send(8'h11);
      idle();
      chk("len17_err_pulse", 32'(err),      32'd1);
      chk("len17_err_code",  32'(err_code), 32'd2);
      chk("len17_vec_len",   32'(vec_len),  32'd3);

      // reset in the middle of a matrix body
      send(8'h02); send(8'h02); send(8'h03);
      send(8'hA0); send(8'hA1);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mrst_busy",     32'(busy),     32'd0);
      chk("mrst_vec_len",  32'(vec_len),  32'd0);
      chk("mrst_mm_valid", 32'(mm_valid), 32'd0);
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      wr_q.delete();
      send(8'h01); send(8'h02); send(8'h55); send(8'h66);
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("post_rst_wr_count", 32'(wr_q.size()), 32'd2);
      if (wr_q.size() == 2) begin
         chk("post_rst_wr0", 32'({wr_q[0].a, wr_q[0].d}), 32'({10'd0, 8'h55}));
         chk("post_rst_wr1", 32'({wr_q[1].a, wr_q[1].d}), 32'({10'd1, 8'h66}));
      end
      chk("post_rst_vec_len", 32'(vec_len), 32'd2);

      // back-to-back LOAD_VEC 16 then MATMUL 255x16
      mm_q.delete();
      send(8'h01); send(8'h10);
      for (int i = 0; i < 16; i++) send(8'(8'h20 + i));
      h = last_acc;
      send(8'h02);
      chk("b2b_opcode_next_cycle", 32'(last_acc - h), 32'd1);
      send(8'hFF); send(8'h10);
      h = last_acc;
      for (int i = 0; i < 4080; i++) send(8'(i));
      chk("b2b_body_cycles", 32'(last_acc - h), 32'd4082);
      idle();
      chk("b2b_busy_after", 32'(busy),     32'd0);
      chk("b2b_in_ready",   32'(in_ready), 32'd1);
      chk("b2b_vec_len",    32'(vec_len),  32'd16);
      repeat (2) @(negedge clk);
      #1;
      chk("b2b_mm_count", 32'(mm_q.size()), 32'd4082);
      bad = 0;
      if (mm_q.size() == 4082) begin
         if (mm_q[0] !== 8'hFF) bad++;
         if (mm_q[1] !== 8'h10) bad++;
         for (int i = 0; i < 4080; i++)
            if (mm_q[i + 2] !== 8'(i)) bad++;
      end else begin
         bad = 1;
      end
      chk("b2b_mm_content", 32'(bad), 32'd0);
      chk("total_err_pulses", 32'(err_cnt), 32'd4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
